loop_scheduler: RTL and testbench
=================================

# loop_scheduler

Nested-loop issue controller that walks a (2^IDX_W) x (2^IDX_W) index space (outer i, inner j), issuing one operand-index pair per unstalled cycle to the counter-driven MAC datapath. It tracks the datapath pipeline latency so that it can produce delayed write enables and a single done pulse. It sits between the top-level start/done handshake and the datapath's index counters and write port, and replaces ad-hoc count_en wiring with one sequenced controller.

## Interface
- IDX_W, 2, width of each loop index; each loop runs 2^IDX_W iterations.
- PIPE_LAT, 2, datapath latency in cycles from issue to write; legal range 1..8.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- stall  in  1  datapath back-pressure; blocks issue only.
- abort  in  1  synchronous cancel of the current pass.
- idx_i  out  IDX_W  outer index of the current issue (registered).
- idx_j  out  IDX_W  inner index of the current issue (registered).
- issue_valid  out  1  idx_i/idx_j are being issued this cycle.
- issue_last  out  1  current issue is (max, max).
- wr_en  out  1  issue_valid delayed by PIPE_LAT cycles.
- wr_last  out  1  issue_last delayed by PIPE_LAT cycles.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse marking completion of a pass.

## Operation
- The FSM has five states: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE: start=1 moves to CLR. start is ignored in every other state.
- CLR: lasts one cycle. Clears idx_i, idx_j and the delay line, then moves to RUN.
- RUN, stall=0:
  - issue_valid=1.
  - idx_j increments. On idx_j == max, idx_j wraps to 0 and idx_i increments.
  - On the (max, max) issue, issue_last=1 and the next state is DRAIN. The indices wrap to 0.
- RUN, stall=1: issue_valid=0 and the indices hold.
- Stall never affects the delay line.
- issue_valid = (state==RUN) & ~stall. This output is combinational.
- issue_last = issue_valid & idx_i==max & idx_j==max.
- The delay line is a PIPE_LAT-deep shift register carrying {issue_valid, issue_last}. It shifts every cycle.
- DRAIN: wait for wr_last=1. On that cycle, move to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- abort=1 in CLR, RUN, DRAIN or DONE:
  - The next state is IDLE, the indices are cleared and the delay line is flushed.
  - No done pulse is produced.
  - abort wins over every other transition in the same cycle. abort in IDLE has no effect.
- Every pass issues exactly 2^(2*IDX_W) pairs, each exactly once, in row-major order.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - idx_i=0, idx_j=0, the delay line is cleared.
  - issue_valid, issue_last, wr_en, wr_last, busy and done are all 0.
  - Reset released mid-pass resumes in IDLE.
- Write-back latency: wr_en for an issue at cycle t asserts at cycle t+PIPE_LAT.
- Pass latency with no stall, start sampled at cycle 0 (N = 2^IDX_W):
  - CLR at cycle 1.
  - Issues at cycles 2 .. N*N+1.
  - wr_last at cycle N*N+1+PIPE_LAT.
  - done at cycle N*N+2+PIPE_LAT.
  - busy is high from cycle 1 through the done cycle.
- Each stalled RUN cycle adds exactly one cycle to the pass.
- A stall during DRAIN has no effect.
- start asserted in the done cycle is ignored. A new pass needs start while in IDLE, so the minimum gap between passes is 1 idle cycle.

## Test plan
- Reset, then start=1 for one cycle, IDX_W=2, PIPE_LAT=2, stall=0:
  - 16 issues at cycles 2..17 in order (0,0),(0,1)..(3,3).
  - issue_last at cycle 17, wr_en at cycles 4..19, wr_last at cycle 19.
  - done at cycle 20, busy high 1..20.
- stall=1 during cycles 5-7 and during the (3,3) issue cycle:
  - Indices hold, no duplicated or skipped pairs.
  - done arrives 4 cycles later than in the unstalled pass (cycle 24).
- abort=1 at cycle 10:
  - IDLE at cycle 11, wr_en stops immediately, no done pulse.
  - A following start runs a full clean pass beginning at (0,0).
- rst=0 asserted mid-RUN (idx=(2,1)):
  - All outputs go to 0 immediately.
  - After release, start gives a normal 20-cycle pass.
- start held high continuously:
  - Back-to-back passes separated by exactly one IDLE cycle.
  - start during busy has no effect.
- PIPE_LAT=1 and PIPE_LAT=8: wr_last and done shift to issue_last+1/+2 and issue_last+8/+9 respectively.

Source files
------------

// File: rtl/loop_scheduler.sv
// loop_scheduler: walks a 2^IDX_W x 2^IDX_W index space in row-major order, one pair per
// unstalled cycle, and delays issue flags by PIPE_LAT to form write enables and a done pulse.
module loop_scheduler #(
    parameter int IDX_W    = 2,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             abort,
    output logic [IDX_W-1:0] idx_i,
    output logic [IDX_W-1:0] idx_j,
    output logic             issue_valid,
    output logic             issue_last,
    output logic             wr_en,
    output logic             wr_last,
    output logic             busy,
    output logic             done
);
    localparam int CW = 2 * IDX_W;

    typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;

    state_t              state, state_d;
    logic [CW-1:0]       cnt;
    logic [PIPE_LAT-1:0] dl_v, dl_l;
    logic                kill, clear;

    // {i, j} as one counter: carry out of j is exactly the row-major step of i
    assign idx_i   = cnt[CW-1:IDX_W];
    assign idx_j   = cnt[IDX_W-1:0];
    assign wr_en   = dl_v[PIPE_LAT-1];
    assign wr_last = dl_l[PIPE_LAT-1];
    assign kill    = abort && state != IDLE;
    assign clear   = kill || state == CLR;

    always_comb begin
        state_d     = state;
        issue_valid = state == RUN && !stall;
        issue_last  = issue_valid && (&cnt);
        busy        = state != IDLE;
        done        = state == DONE && !abort;
        case (state)
            IDLE:    state_d = start ? CLR : IDLE;
            CLR:     state_d = RUN;
            RUN:     state_d = issue_last ? DRAIN : RUN;
            DRAIN:   state_d = wr_last ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             cnt <= '0;
        else if (clear)       cnt <= '0;
        else if (issue_valid) cnt <= cnt + CW'(1);
    end

    // shifts every cycle regardless of stall; an aborted issue never reaches the write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_v <= '0;
            dl_l <= '0;
        end else if (clear) begin
            dl_v <= '0;
            dl_l <= '0;
        end else begin
            dl_v <= PIPE_LAT'({dl_v, issue_valid});
            dl_l <= PIPE_LAT'({dl_l, issue_last});
        end
    end
endmodule

// File: tb/tb_loop_scheduler.sv
// tb_loop_scheduler: three latency variants on shared stimulus, each checked by a
// queue scoreboard fed from a pass-level reference model.
module tb_loop_scheduler;
    localparam int W  = 2;
    localparam int N  = 1 << W;
    localparam int NN = N * N;
    localparam int NI = 3;

    typedef struct {int c; int i; int j; bit last;} iss_t;
    typedef struct {int c; bit last;} wr_t;

    logic clk = 0, rst = 1, start = 0, stall = 0, abort = 0;
    int   cyc = 0, total = 0, bad = 0;
    int   lats[NI] = '{2, 1, 8};
    int   done_seen[NI], done_prev[NI];
    event fin_ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : u
        localparam int L = g == 0 ? 2 : g == 1 ? 1 : 8;
        logic [W-1:0] ii, jj;
        logic iv, il, we, wl, bz, dn;
        iss_t iq[$];
        wr_t  wq[$];
        int   dq[$];
        bit   act = 0, exp_busy = 0;
        int   t = 0, k = 0, done_at = -1;

        loop_scheduler #(.IDX_W(W), .PIPE_LAT(L)) dut (
            .clk(clk), .rst(rst), .start(start), .stall(stall), .abort(abort),
            .idx_i(ii), .idx_j(jj), .issue_valid(iv), .issue_last(il),
            .wr_en(we), .wr_last(wl), .busy(bz), .done(dn)
        );

        // pass-level model: k-th unstalled RUN cycle issues pair k, written L cycles later
        always @(posedge clk) begin
            iss_t e;
            wr_t  w;
            #2;
            if (!rst) begin
                act = 0;
                exp_busy = 0;
            end else if (!act) begin
                exp_busy = 0;
                if (start) begin
                    act = 1; t = 0; k = 0; done_at = -1;
                end
            end else begin
                exp_busy = 1;
                t++;
                if (t > 1 && k < NN && !stall) begin
                    e.c = cyc; e.i = k / N; e.j = k % N; e.last = (k == NN - 1);
                    iq.push_back(e);
                    if (!abort) begin
                        w.c = cyc + L; w.last = e.last;
                        wq.push_back(w);
                    end
                    k++;
                    if (k == NN) done_at = cyc + L + 1;
                end else if (cyc == done_at) begin
                    if (!abort) dq.push_back(cyc);
                    act = 0;
                end
                if (abort) begin
                    act = 0;
                    while (wq.size() > 0 && wq[$].c > cyc) void'(wq.pop_back());
                end
            end
        end

        always @(negedge rst) begin
            iq.delete(); wq.delete(); dq.delete();
            act = 0; exp_busy = 0;
        end

        always @(negedge clk) begin
            bit en;
            if (!rst) begin
                total++;
                if ({iv, il, we, wl, bz, dn} !== 6'b0) begin
                    bad++;
                    $display("FAIL reset_outs L=%0d cyc=%0d got=%b want=000000", L, cyc, {iv, il, we, wl, bz, dn});
                end
            end else begin
                total++;
                if (bz !== exp_busy) begin
                    bad++;
                    $display("FAIL busy L=%0d cyc=%0d got=%b want=%b", L, cyc, bz, exp_busy);
                end
                en = iq.size() > 0 && iq[0].c == cyc;
                if (iv || il || en) begin
                    total++;
                    if (!(iv === 1'b1 && en && int'(ii) == iq[0].i && int'(jj) == iq[0].j && il === iq[0].last)) begin
                        bad++;
                        $display("FAIL issue L=%0d cyc=%0d got v=%b (%0d,%0d) last=%b want v=%b (%0d,%0d) last=%b",
                                 L, cyc, iv, ii, jj, il, en, en ? iq[0].i : -1, en ? iq[0].j : -1, en ? iq[0].last : 1'b0);
                    end
                    if (en) void'(iq.pop_front());
                end
                en = wq.size() > 0 && wq[0].c == cyc;
                if (we || wl || en) begin
                    total++;
                    if (!(we === 1'b1 && en && wl === wq[0].last)) begin
                        bad++;
                        $display("FAIL write L=%0d cyc=%0d got en=%b last=%b want en=%b last=%b",
                                 L, cyc, we, wl, en, en ? wq[0].last : 1'b0);
                    end
                    if (en) void'(wq.pop_front());
                end
                en = dq.size() > 0 && dq[0] == cyc;
                if (dn || en) begin
                    total++;
                    if (!(dn === 1'b1 && en)) begin
                        bad++;
                        $display("FAIL done L=%0d cyc=%0d got=%b want=%b", L, cyc, dn, en);
                    end
                    if (en) void'(dq.pop_front());
                end
                if (dn) begin
                    done_prev[g] = done_seen[g];
                    done_seen[g] = cyc;
                end
            end
        end

        always @(fin_ev) begin
            total++;
            if (iq.size() + wq.size() + dq.size() != 0) begin
                bad++;
                $display("FAIL leftover L=%0d got=%0d/%0d/%0d want=0/0/0", L, iq.size(), wq.size(), dq.size());
            end
        end
    end

    task automatic drive(input bit s, input bit sl, input bit ab);
        @(posedge clk);
        #1;
        start = s; stall = sl; abort = ab;
    endtask

    task automatic clr_done();
        for (int g = 0; g < NI; g++) begin
            done_seen[g] = -1;
            done_prev[g] = -1;
        end
    endtask

    task automatic check_done(input int s, input int base, input string nm);
        for (int g = 0; g < NI; g++) begin
            total++;
            if (done_seen[g] - s != base + lats[g]) begin
                bad++;
                $display("FAIL %s L=%0d done at +%0d want +%0d", nm, lats[g], done_seen[g] - s, base + lats[g]);
            end
        end
    endtask

    task automatic clean_pass(input string nm);
        int s;
        clr_done();
        drive(1, 0, 0);
        s = cyc;
        repeat (30) drive(0, 0, 0);
        check_done(s, NN + 2, nm);
    endtask

    initial begin
        int s;
        #1 rst = 0;
        repeat (3) drive(0, 0, 0);
        rst = 1;
        drive(0, 0, 0);

        clean_pass("plain_pass");

        clr_done();
        drive(1, 0, 0);
        s = cyc;
        for (int r = 1; r <= 34; r++) drive(0, r inside {5, 6, 7, 20}, 0);
        check_done(s, NN + 6, "stall_pass");

        clr_done();
        drive(1, 0, 0);
        s = cyc;
        for (int r = 1; r <= 30; r++) drive(0, 0, r == 10);
        for (int g = 0; g < NI; g++) begin
            total++;
            if (done_seen[g] != -1) begin
                bad++;
                $display("FAIL abort_nodone L=%0d got done at +%0d want none", lats[g], done_seen[g] - s);
            end
        end
        clean_pass("after_abort");

        drive(1, 0, 0);
        for (int r = 1; r <= 11; r++) drive(0, 0, 0);
        #2 rst = 0;
        repeat (2) drive(0, 0, 0);
        rst = 1;
        clean_pass("after_reset");

        clr_done();
        drive(1, 0, 0);
        for (int r = 1; r <= 53; r++) drive(1, 0, 0);
        repeat (40) drive(0, 0, 0);
        for (int g = 0; g < NI; g++) begin
            total++;
            if (done_prev[g] < 0 || done_seen[g] - done_prev[g] != NN + 3 + lats[g]) begin
                bad++;
                $display("FAIL back_to_back L=%0d got gap=%0d want gap=%0d", lats[g], done_seen[g] - done_prev[g], NN + 3 + lats[g]);
            end
        end

        repeat (2500) drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
        repeat (40) drive(0, 0, 0);
        ->fin_ev;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
